// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_arbiter
// Summary  : Shares one pipelined ALU between two valid/ready requesters and
//            routes each result back to its originator in issue order.
//            Define ALU_ARB_FIXED_PRIO_EN for fixed priority (port 0 wins);
//            otherwise contended cycles are resolved round-robin.
// Revision : 1.0 - initial release
// ============================================================================
module alu_arbiter #(
    parameter int DATA_WIDTH   = 32,
    parameter int CTRL_WIDTH   = 6,
    parameter int STATUS_WIDTH = 4,
    parameter int SHAMT_WIDTH  = 5,
    parameter int DELAY        = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic [1:0]                req_valid,
    output logic [1:0]                req_ready,
    input  logic [4*DATA_WIDTH-1:0]   req_data,
    input  logic [2*CTRL_WIDTH-1:0]   req_ctrl,
    input  logic [2*SHAMT_WIDTH-1:0]  req_shamt,
    output logic [1:0]                rsp_valid,
    output logic [DATA_WIDTH-1:0]     rsp_data,
    output logic [STATUS_WIDTH-1:0]   rsp_status,
    output logic [2*DATA_WIDTH-1:0]   alu_dataIn,
    output logic [CTRL_WIDTH-1:0]     alu_ctrl,
    output logic [SHAMT_WIDTH-1:0]    alu_shamt,
    input  logic [DATA_WIDTH-1:0]     alu_dataOut,
    input  logic [STATUS_WIDTH-1:0]   alu_status
);

    logic [1:0]              grant;
    logic                    handshake;
    logic                    grant_id;

    logic [2*DATA_WIDTH-1:0] sel_data;
    logic [CTRL_WIDTH-1:0]   sel_ctrl;
    logic [SHAMT_WIDTH-1:0]  sel_shamt;

    logic [2*DATA_WIDTH-1:0] issue_data_q,  issue_data_d;
    logic [CTRL_WIDTH-1:0]   issue_ctrl_q,  issue_ctrl_d;
    logic [SHAMT_WIDTH-1:0]  issue_shamt_q, issue_shamt_d;

    logic [DELAY:0]          tag_vld_q, tag_vld_d;
    logic [DELAY:0]          tag_id_q,  tag_id_d;

    logic                    rsp_fire;
    logic [1:0]              rsp_valid_q,  rsp_valid_d;
    logic [DATA_WIDTH-1:0]   rsp_data_q,   rsp_data_d;
    logic [STATUS_WIDTH-1:0] rsp_status_q, rsp_status_d;

`ifndef ALU_ARB_FIXED_PRIO_EN
    logic                    rr_last_q, rr_last_d;
`endif

    // Grant is gated by rst so req_ready reads 0 while reset is asserted.
    always_comb begin
        grant = 2'b00;
        if (!rst && !flush) begin
            case (req_valid)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11: begin
`ifdef ALU_ARB_FIXED_PRIO_EN
                    grant = 2'b01;
`else
                    grant = rr_last_q ? 2'b01 : 2'b10;
`endif
                end
                default: grant = 2'b00;
            endcase
        end
    end

    assign req_ready = grant;
    assign handshake = |grant;
    assign grant_id  = grant[1];

    always_comb begin
        sel_data  = grant_id ? req_data[4*DATA_WIDTH-1:2*DATA_WIDTH]
                             : req_data[2*DATA_WIDTH-1:0];
        sel_ctrl  = grant_id ? req_ctrl[2*CTRL_WIDTH-1:CTRL_WIDTH]
                             : req_ctrl[CTRL_WIDTH-1:0];
        sel_shamt = grant_id ? req_shamt[2*SHAMT_WIDTH-1:SHAMT_WIDTH]
                             : req_shamt[SHAMT_WIDTH-1:0];
    end

`ifndef ALU_ARB_FIXED_PRIO_EN
    assign rr_last_d = handshake ? grant_id : rr_last_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_last_q <= 1'b1;
        end else begin
            rr_last_q <= rr_last_d;
        end
    end
`endif

    always_comb begin
        issue_data_d  = issue_data_q;
        issue_ctrl_d  = issue_ctrl_q;
        issue_shamt_d = issue_shamt_q;
        if (handshake) begin
            issue_data_d  = sel_data;
            issue_ctrl_d  = sel_ctrl;
            issue_shamt_d = sel_shamt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            issue_data_q  <= '0;
            issue_ctrl_q  <= '0;
            issue_shamt_q <= '0;
        end else begin
            issue_data_q  <= issue_data_d;
            issue_ctrl_q  <= issue_ctrl_d;
            issue_shamt_q <= issue_shamt_d;
        end
    end

    assign alu_dataIn = issue_data_q;
    assign alu_ctrl   = issue_ctrl_q;
    assign alu_shamt  = issue_shamt_q;

    // Stage k holds the op whose ALU inputs were presented k cycles ago;
    // stage DELAY lines up with a valid alu_dataOut. No handshake occurs
    // during flush, so stage 0 is already clear then.
    assign tag_vld_d[0] = handshake;
    assign tag_id_d[0]  = grant_id;

    generate
        if (DELAY > 0) begin : g_tag_shift
            assign tag_vld_d[DELAY:1] = flush ? '0 : tag_vld_q[DELAY-1:0];
            assign tag_id_d[DELAY:1]  = tag_id_q[DELAY-1:0];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_vld_q <= '0;
            tag_id_q  <= '0;
        end else begin
            tag_vld_q <= tag_vld_d;
            tag_id_q  <= tag_id_d;
        end
    end

    // Capture is suppressed on flush so rsp_data/status never move without a strobe.
    assign rsp_fire = tag_vld_q[DELAY] && !flush;

    always_comb begin
        rsp_valid_d  = 2'b00;
        rsp_data_d   = rsp_data_q;
        rsp_status_d = rsp_status_q;
        if (rsp_fire) begin
            rsp_valid_d  = tag_id_q[DELAY] ? 2'b10 : 2'b01;
            rsp_data_d   = alu_dataOut;
            rsp_status_d = alu_status;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid_q  <= 2'b00;
            rsp_data_q   <= '0;
            rsp_status_q <= '0;
        end else begin
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_q   <= rsp_data_d;
            rsp_status_q <= rsp_status_d;
        end
    end

    assign rsp_valid  = rsp_valid_q;
    assign rsp_data   = rsp_data_q;
    assign rsp_status = rsp_status_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_arbiter
// Summary  : Drives two alu_arbiter instances (DELAY 0 and DELAY 2) with the
//            same stimulus, each attached to its own ALU model, and compares
//            them against a due-time scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_arbiter;

    localparam int DW = 32;
    localparam int CW = 6;
    localparam int SW = 4;
    localparam int HW = 5;
    localparam logic [5:0] OP_ADD = 6'd0;
    localparam logic [5:0] OP_SUB = 6'd1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              flush = 1'b0;
    logic [1:0]        req_valid = 2'b00;
    logic [4*DW-1:0]   req_data = '0;
    logic [2*CW-1:0]   req_ctrl = '0;
    logic [2*HW-1:0]   req_shamt = '0;

    logic [1:0][1:0]      rdy, rspv;
    logic [1:0][DW-1:0]   rspd, ado;
    logic [1:0][SW-1:0]   rsps, ast;
    logic [1:0][2*DW-1:0] adi;
    logic [1:0][CW-1:0]   actl;
    logic [1:0][HW-1:0]   ash;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW), .STATUS_WIDTH(SW),
                  .SHAMT_WIDTH(HW), .DELAY(0)) u_dut0 (
        .clk(clk), .rst(rst), .flush(flush),
        .req_valid(req_valid), .req_ready(rdy[0]),
        .req_data(req_data), .req_ctrl(req_ctrl), .req_shamt(req_shamt),
        .rsp_valid(rspv[0]), .rsp_data(rspd[0]), .rsp_status(rsps[0]),
        .alu_dataIn(adi[0]), .alu_ctrl(actl[0]), .alu_shamt(ash[0]),
        .alu_dataOut(ado[0]), .alu_status(ast[0])
    );

    alu_arbiter #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW), .STATUS_WIDTH(SW),
                  .SHAMT_WIDTH(HW), .DELAY(2)) u_dut1 (
        .clk(clk), .rst(rst), .flush(flush),
        .req_valid(req_valid), .req_ready(rdy[1]),
        .req_data(req_data), .req_ctrl(req_ctrl), .req_shamt(req_shamt),
        .rsp_valid(rspv[1]), .rsp_data(rspd[1]), .rsp_status(rsps[1]),
        .alu_dataIn(adi[1]), .alu_ctrl(actl[1]), .alu_shamt(ash[1]),
        .alu_dataOut(ado[1]), .alu_status(ast[1])
    );

    // Reference ALU: returns {status, result}.
    function automatic logic [35:0] alu_f(input logic [63:0] ab, input logic [5:0] op,
                                          input logic [4:0] sh);
        logic [31:0] a, b, r;
        a = ab[63:32];
        b = ab[31:0];
        case (op)
            6'd0:    r = a + b;
            6'd1:    r = a - b;
            6'd2:    r = a & b;
            6'd3:    r = a | b;
            6'd4:    r = a ^ b;
            6'd5:    r = a << sh;
            6'd6:    r = a >> sh;
            default: r = ~a;
        endcase
        return {(r == 32'd0), r[31], r[0], ^op, r};
    endfunction

    logic [35:0] alu0_res, alu1_p1, alu1_p2;
    always_comb alu0_res = alu_f(adi[0], actl[0], ash[0]);
    always @(posedge clk) begin
        alu1_p1 <= alu_f(adi[1], actl[1], ash[1]);
        alu1_p2 <= alu1_p1;
    end
    assign ado[0] = alu0_res[31:0];
    assign ast[0] = alu0_res[35:32];
    assign ado[1] = alu1_p2[31:0];
    assign ast[1] = alu1_p2[35:32];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Scoreboard: expected response indexed by the cycle it must appear in.
    bit          exp_v  [2][8];
    bit          exp_id [2][8];
    logic [35:0] exp_r  [2][8];
    logic [35:0] last_r [2];
    bit          rr_model = 1'b1;
    int          cyc = 0;

    always @(negedge clk) begin
        logic [1:0]  g;
        logic [35:0] r;
        int          slot, idx;
        if (rst) begin
            for (int d = 0; d < 2; d++) begin
                for (int s = 0; s < 8; s++) exp_v[d][s] = 1'b0;
                last_r[d] = '0;
                chk("rst_ready", rdy[d], 0);
                chk("rst_rsp_valid", rspv[d], 0);
                chk("rst_rsp_data", rspd[d], 0);
                chk("rst_rsp_status", rsps[d], 0);
                chk("rst_alu_dataIn", adi[d], 0);
                chk("rst_alu_ctrl", actl[d], 0);
                chk("rst_alu_shamt", ash[d], 0);
            end
            rr_model = 1'b1;
        end else begin
            g = 2'b00;
            if (!flush) begin
                if (req_valid == 2'b11) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
                    g = 2'b01;
`else
                    g = rr_model ? 2'b01 : 2'b10;
`endif
                end else begin
                    g = req_valid;
                end
            end
            for (int d = 0; d < 2; d++) begin
                slot = cyc % 8;
                chk(d == 0 ? "sb_ready_d0" : "sb_ready_d2", rdy[d], g);
                chk(d == 0 ? "sb_rsp_valid_d0" : "sb_rsp_valid_d2", rspv[d],
                    exp_v[d][slot] ? (exp_id[d][slot] ? 2'b10 : 2'b01) : 2'b00);
                if (exp_v[d][slot]) last_r[d] = exp_r[d][slot];
                chk(d == 0 ? "sb_rsp_data_d0" : "sb_rsp_data_d2", rspd[d], last_r[d][31:0]);
                chk(d == 0 ? "sb_rsp_status_d0" : "sb_rsp_status_d2", rsps[d], last_r[d][35:32]);
                exp_v[d][slot] = 1'b0;
                if (flush) begin
                    for (int s = 0; s < 8; s++) exp_v[d][s] = 1'b0;
                end
                if (g != 2'b00) begin
                    idx = g[1] ? 1 : 0;
                    r = alu_f(req_data[idx*64 +: 64], req_ctrl[idx*6 +: 6], req_shamt[idx*5 +: 5]);
                    slot = (cyc + (d == 0 ? 2 : 4)) % 8;
                    exp_v[d][slot]  = 1'b1;
                    exp_id[d][slot] = g[1];
                    exp_r[d][slot]  = r;
                end
            end
            if (g != 2'b00) rr_model = g[1];
        end
        cyc++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = 2'b00;
        flush = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic set_req(input int p, input logic [31:0] a, input logic [31:0] b,
                           input logic [5:0] op);
        req_data[p*64 +: 64] = {a, b};
        req_ctrl[p*6 +: 6]   = op;
        req_shamt[p*5 +: 5]  = 5'd0;
    endtask

    logic [1:0] gexp [8];

    initial begin
`ifdef ALU_ARB_FIXED_PRIO_EN
        gexp = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b10};
`else
        gexp = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b10};
`endif
        do_reset();

        // Single ADD from port 0
        set_req(0, 32'd5, 32'd3, OP_ADD);
        req_valid = 2'b01;
        @(negedge clk);
        chk("t1_ready", rdy[0], 2'b01);
        tick();
        req_valid = 2'b00;
        tick();
        @(negedge clk);
        chk("t1_rsp_valid", rspv[0], 2'b01);
        chk("t1_rsp_data", rspd[0], 32'd8);
        tick();
        tick();
        @(negedge clk);
        chk("t1_rsp_valid_d2", rspv[1], 2'b01);
        chk("t1_rsp_data_d2", rspd[1], 32'd8);
        tick();

        // Both valid for six cycles, then port 0 drops
        do_reset();
        set_req(0, 32'd7, 32'd2, OP_ADD);
        set_req(1, 32'd7, 32'd2, OP_SUB);
        req_valid = 2'b11;
        for (int i = 0; i < 8; i++) begin
            if (i >= 6) req_valid = 2'b10;
            @(negedge clk);
            chk("t2_grant", rdy[0], gexp[i]);
            if (i >= 2) begin
                chk("t2_rsp_strobe", rspv[0], gexp[i-2]);
                chk("t2_rsp_data", rspd[0], gexp[i-2] == 2'b01 ? 32'd9 : 32'd5);
            end
            tick();
        end
        req_valid = 2'b00;

        // Back-to-back SUBs from port 1, checked on the DELAY=2 instance
        do_reset();
        for (int i = 0; i < 8; i++) begin
            if (i < 4) begin
                req_valid = 2'b10;
                set_req(1, 32'd10, 32'(i + 1), OP_SUB);
            end else begin
                req_valid = 2'b00;
            end
            @(negedge clk);
            if (i < 4) begin
                chk("t3_grant", rdy[1], 2'b10);
                chk("t3_no_early_rsp", rspv[1], 2'b00);
            end else begin
                chk("t3_rsp_strobe", rspv[1], 2'b10);
                chk("t3_rsp_data", rspd[1], 32'(10 - (i - 3)));
            end
            tick();
        end

        // Flush with ops in flight
        do_reset();
        for (int i = 0; i < 8; i++) begin
            case (i)
                0: begin req_valid = 2'b01; set_req(0, 32'd4, 32'd4, OP_ADD); end
                1: set_req(0, 32'd5, 32'd5, OP_ADD);
                2: flush = 1'b1;
                3: begin flush = 1'b0; set_req(0, 32'd1, 32'd1, OP_ADD); end
                4: req_valid = 2'b00;
                default: ;
            endcase
            @(negedge clk);
            if (i == 2) chk("t4_flush_ready", rdy[0], 2'b00);
            if (i == 3) chk("t4_post_flush_ready", rdy[0], 2'b01);
            if (i == 2) chk("t4_d0_pre_flush_rsp", rspd[0], 32'd8);
            if (i == 3 || i == 4) chk("t4_d0_killed", rspv[0], 2'b00);
            if (i == 5) begin
                chk("t4_d0_rsp", rspv[0], 2'b01);
                chk("t4_d0_data", rspd[0], 32'd2);
            end
            if (i >= 2 && i <= 6) chk("t4_d2_killed", rspv[1], 2'b00);
            if (i == 7) begin
                chk("t4_d2_rsp", rspv[1], 2'b01);
                chk("t4_d2_data", rspd[1], 32'd2);
            end
            tick();
        end

        // Asynchronous reset in the middle of a burst
        do_reset();
        set_req(0, 32'd20, 32'd3, OP_ADD);
        set_req(1, 32'd20, 32'd3, OP_SUB);
        req_valid = 2'b11;
        tick();
        tick();
        tick();
        #2;
        rst = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("t5_async_ready", rdy[d], 0);
            chk("t5_async_rsp_valid", rspv[d], 0);
            chk("t5_async_rsp_data", rspd[d], 0);
            chk("t5_async_alu_dataIn", adi[d], 0);
        end
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("t5_first_grant", rdy[0], 2'b01);
        tick();
        req_valid = 2'b00;
        for (int i = 0; i < 6; i++) tick();

        // Randomized traffic, flushes and occasional async resets
        for (int i = 0; i < 600; i++) begin
            req_valid = 2'($urandom);
            req_data  = {$urandom, $urandom, $urandom, $urandom};
            req_ctrl  = {6'($urandom_range(0, 7)), 6'($urandom_range(0, 7))};
            req_shamt = 10'($urandom);
            flush     = ($urandom_range(0, 11) == 0);
            if ($urandom_range(0, 149) == 0) begin
                #2;
                rst = 1'b1;
                tick();
                rst = 1'b0;
            end else begin
                tick();
            end
        end
        req_valid = 2'b00;
        flush = 1'b0;
        for (int i = 0; i < 6; i++) tick();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
`default_nettype wire
